// File: rtl/com_sw_to_fw_pkg.sv
// com_sw_to_fw_pkg: op-codes, command field positions, FSM states and status bits for the SW-to-FW sequencer
package com_sw_to_fw_pkg;
  typedef enum logic [3:0] {
    OP_CODE_NOOP      = 4'h0,
    OP_CODE_W_RST_FW  = 4'h1,
    OP_CODE_WRITE     = 4'h2,
    OP_CODE_READ      = 4'h3,
    OP_CODE_W_CFG     = 4'h4,
    OP_CODE_R_CFG     = 4'h5,
    OP_CODE_START     = 4'h6,
    OP_CODE_STOP      = 4'h7,
    OP_CODE_USER8     = 4'h8,
    OP_CODE_USER9     = 4'h9,
    OP_CODE_USERA     = 4'hA,
    OP_CODE_USERB     = 4'hB,
    OP_CODE_USERC     = 4'hC,
    OP_CODE_USERD     = 4'hD,
    OP_CODE_LOCAL_CLR = 4'hE,
    OP_CODE_EXECUTE   = 4'hF
  } op_code_e;
  localparam int DEV_HI = 31;
  localparam int DEV_LO = 28;
  localparam int OP_HI = 27;
  localparam int OP_LO = 24;
  localparam int BODY_HI = 23;
  localparam int BODY_LO = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_e;
  localparam int ST_BUSY = 31;
  localparam int ST_TIMEOUT = 30;
  localparam int ST_INVALID = 29;
  localparam int ST_OVERRUN = 28;
endpackage

// File: rtl/com_cmd_validate.sv
// com_cmd_validate: decodes the command header into device validity, device index, NOOP and local-clear flags
module com_cmd_validate
  import com_sw_to_fw_pkg::*;
#(
  parameter int NUM_FW = 4
) (
  input  logic [7:0] hdr,
  output logic       valid_dev,
  output logic [1:0] dev_index,
  output logic       is_noop,
  output logic       is_local_clear
);
  logic [3:0] dev;
  logic [3:0] op;
  always_comb begin
    dev = hdr[DEV_HI-OP_LO:DEV_LO-OP_LO];
    op = hdr[OP_HI-OP_LO:0];
    dev_index = 2'd0;
    for (int i = 0; i < 4; i++) dev_index = dev[i] ? 2'(i) : dev_index;
    valid_dev = dev != 4'd0 && (dev & (dev - 4'd1)) == 4'd0 && 32'(dev_index) < NUM_FW;
    is_noop = valid_dev && op == OP_CODE_NOOP;
    is_local_clear = dev == 4'd0 && op == OP_CODE_LOCAL_CLR;
  end
endmodule

// File: rtl/com_sw_to_fw_seq.sv
// com_sw_to_fw_seq: registered SW-to-FW command sequencer with strobe, ack/timeout, pending slot and status
module com_sw_to_fw_seq
  import com_sw_to_fw_pkg::*;
#(
  parameter int NUM_FW = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   fw_clk_100,
  input  logic                   fw_rst,
  input  logic [31:0]            sw_write32_0,
  output logic [31:0]            sw_read32_0,
  output logic [31:0]            sw_read32_1,
  output logic [31:0]            sw_read32_2,
  output logic [NUM_FW-1:0]      fw_dev_id_enable,
  output logic [3:0]             fw_op_code,
  output logic [15:0]            fw_op_code_strobe,
  output logic [23:0]            sw_write24_0,
  input  logic [NUM_FW-1:0]      fw_ack,
  input  logic [NUM_FW-1:0][31:0] fw_read_data32,
  input  logic [NUM_FW-1:0][31:0] fw_read_status32
);
  localparam int TW = ACK_TIMEOUT > 2 ? $clog2(ACK_TIMEOUT) : 1;
  state_e state;
  logic [31:0] word_q;
  logic [TW-1:0] tmr;
  logic busy, timeout_err, invalid_err, overrun_err;
  logic [CNT_WIDTH-1:0] cmd_count;
  logic [NUM_FW-1:0] sel, pend_en, in_en;
  logic pend_v;
  logic [3:0] pend_op;
  logic [23:0] pend_body;
  logic valid_dev, is_noop, is_local_clear, new_cmd, acc, ack_hit;
  logic [1:0] dev_index;
  logic [31:0] rd_data, rd_stat, status;
  com_cmd_validate #(.NUM_FW(NUM_FW)) u_val (
    .hdr(sw_write32_0[DEV_HI:OP_LO]),
    .valid_dev(valid_dev),
    .dev_index(dev_index),
    .is_noop(is_noop),
    .is_local_clear(is_local_clear)
  );
  always_comb begin
    new_cmd = sw_write32_0 != word_q;
    acc = new_cmd && valid_dev && !is_noop;
    in_en = NUM_FW'(1) << dev_index;
    ack_hit = |(fw_ack & sel);
    rd_data = '0;
    rd_stat = '0;
    for (int i = 0; i < NUM_FW; i++) begin
      rd_data = fw_dev_id_enable[i] ? fw_read_data32[i] : rd_data;
      rd_stat = fw_dev_id_enable[i] ? fw_read_status32[i] : rd_stat;
    end
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_TIMEOUT] = timeout_err;
    status[ST_INVALID] = invalid_err;
    status[ST_OVERRUN] = overrun_err;
    status[CNT_WIDTH-1:0] = cmd_count;
  end
  always_ff @(posedge fw_clk_100) begin
    if (fw_rst) begin
      state <= IDLE;
      word_q <= '0;
      tmr <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      invalid_err <= 1'b0;
      overrun_err <= 1'b0;
      cmd_count <= '0;
      sel <= '0;
      pend_v <= 1'b0;
      pend_en <= '0;
      pend_op <= '0;
      pend_body <= '0;
      sw_read32_0 <= '0;
      sw_read32_1 <= '0;
      sw_read32_2 <= '0;
      fw_dev_id_enable <= '0;
      fw_op_code <= '0;
      fw_op_code_strobe <= '0;
      sw_write24_0 <= '0;
    end else begin
      word_q <= sw_write32_0;
      fw_op_code_strobe <= '0;
      sw_read32_0 <= rd_data;
      sw_read32_1 <= rd_stat;
      sw_read32_2 <= status;
      if (new_cmd && is_noop) fw_dev_id_enable <= in_en;
      if (new_cmd && !valid_dev && !is_local_clear) invalid_err <= 1'b1;
      case (state)
        IDLE: begin
          if (pend_v) begin
            state <= ISSUE;
            sel <= pend_en;
            fw_dev_id_enable <= pend_en;
            fw_op_code <= pend_op;
            sw_write24_0 <= pend_body;
            pend_v <= acc;
            pend_en <= in_en;
            pend_op <= sw_write32_0[OP_HI:OP_LO];
            pend_body <= sw_write32_0[BODY_HI:BODY_LO];
          end else if (acc) begin
            state <= ISSUE;
            sel <= in_en;
            fw_dev_id_enable <= in_en;
            fw_op_code <= sw_write32_0[OP_HI:OP_LO];
            sw_write24_0 <= sw_write32_0[BODY_HI:BODY_LO];
          end
        end
        ISSUE: begin
          fw_op_code_strobe <= 16'd1 << fw_op_code;
          busy <= 1'b1;
          cmd_count <= cmd_count + 1'b1;
          tmr <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_hit || tmr == TW'(ACK_TIMEOUT - 1)) begin
            state <= IDLE;
            busy <= 1'b0;
            timeout_err <= timeout_err | !ack_hit;
          end else tmr <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && acc) begin
        pend_v <= 1'b1;
        pend_en <= in_en;
        pend_op <= sw_write32_0[OP_HI:OP_LO];
        pend_body <= sw_write32_0[BODY_HI:BODY_LO];
        overrun_err <= overrun_err | pend_v;
      end
      if (new_cmd && is_local_clear) begin
        timeout_err <= 1'b0;
        invalid_err <= 1'b0;
        overrun_err <= 1'b0;
        cmd_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_com_sw_to_fw_seq.sv
// tb_com_sw_to_fw_seq: directed self-checking bench for the SW-to-FW command sequencer
module tb_com_sw_to_fw_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] sw, sw2;
  logic [3:0] ack;
  logic [1:0] ack2;
  logic [3:0][31:0] rdd, rds;
  logic [1:0][31:0] rdd2, rds2;
  logic [31:0] r0, r1, r2, q0, q1, q2;
  logic [3:0] en;
  logic [1:0] en2;
  logic [3:0] op, op2;
  logic [15:0] stb, stb2;
  logic [23:0] body, body2;
  int tests = 0;
  int failed = 0;
  com_sw_to_fw_seq #(.NUM_FW(4), .ACK_TIMEOUT(16), .CNT_WIDTH(16)) dut (
    .fw_clk_100(clk), .fw_rst(rst), .sw_write32_0(sw),
    .sw_read32_0(r0), .sw_read32_1(r1), .sw_read32_2(r2),
    .fw_dev_id_enable(en), .fw_op_code(op), .fw_op_code_strobe(stb), .sw_write24_0(body),
    .fw_ack(ack), .fw_read_data32(rdd), .fw_read_status32(rds)
  );
  com_sw_to_fw_seq #(.NUM_FW(2), .ACK_TIMEOUT(16), .CNT_WIDTH(16)) dut2 (
    .fw_clk_100(clk), .fw_rst(rst), .sw_write32_0(sw2),
    .sw_read32_0(q0), .sw_read32_1(q1), .sw_read32_2(q2),
    .fw_dev_id_enable(en2), .fw_op_code(op2), .fw_op_code_strobe(stb2), .sw_write24_0(body2),
    .fw_ack(ack2), .fw_read_data32(rdd2), .fw_read_status32(rds2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    sw = '0;
    sw2 = '0;
    ack = '0;
    ack2 = '0;
    for (int i = 0; i < 4; i++) begin
      rdd[i] = 32'hD000_0000 + 32'(i);
      rds[i] = 32'h5000_0000 + 32'(i);
    end
    rdd2[0] = 32'h0BAD_F00D;
    rdd2[1] = 32'hDEAD_BEEF;
    rds2 = '0;
    tick;
    tick;
    chk("rst_stb", 32'(stb), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_status", r2, 32'h0);
    chk("rst_rd", r0, 32'h0);
    rst = 1'b0;
    sw = 32'h1600_ABCD;
    tick;
    chk("latch_en", 32'(en), 32'h1);
    chk("latch_body", 32'(body), 32'h00ABCD);
    chk("latch_op", 32'(op), 32'h6);
    chk("pre_stb", 32'(stb), 32'h0);
    tick;
    chk("stb_op6", 32'(stb), 32'h0040);
    tick;
    chk("stb_one_cycle", 32'(stb), 32'h0);
    chk("status_busy", r2, 32'h8000_0001);
    chk("rd_data0", r0, 32'hD000_0000);
    chk("rd_stat0", r1, 32'h5000_0000);
    tick;
    ack = 4'b1110;
    tick;
    ack = 4'b0000;
    tick;
    chk("other_ack_ignored", r2, 32'h8000_0001);
    ack = 4'b0001;
    tick;
    ack = 4'b0000;
    tick;
    chk("busy_drop", r2, 32'h0000_0001);
    sw = 32'h3200_0000;
    tick;
    tick;
    chk("invalid_two_bits", r2, 32'h2000_0001);
    chk("invalid_no_stb", 32'(stb), 32'h0);
    sw = 32'h0E00_0000;
    tick;
    tick;
    chk("local_clear", r2, 32'h0);
    chk("clear_no_stb", 32'(stb), 32'h0);
    sw = 32'h2F00_0001;
    tick;
    tick;
    chk("stb_opf", 32'(stb), 32'h8000);
    chk("en_dev1", 32'(en), 32'h2);
    repeat (16) tick;
    chk("before_timeout", r2, 32'h8000_0001);
    tick;
    chk("timeout", r2, 32'h4000_0001);
    sw = 32'h1700_0002;
    tick;
    tick;
    chk("accept_after_timeout", 32'(stb), 32'h0080);
    sw = 32'h4300_0010;
    tick;
    chk("pend_no_stb", 32'(stb), 32'h0);
    sw = 32'h4500_0020;
    tick;
    chk("overrun_no_stb", 32'(stb), 32'h0);
    ack = 4'b0001;
    tick;
    ack = 4'b0000;
    chk("overrun_flag", r2, 32'hD000_0002);
    chk("ack_edge_no_stb", 32'(stb), 32'h0);
    tick;
    chk("pend_latch_no_stb", 32'(stb), 32'h0);
    chk("pend_body", 32'(body), 32'h000020);
    chk("pend_op", 32'(op), 32'h5);
    tick;
    chk("pend_stb_op5", 32'(stb), 32'h0020);
    chk("pend_en", 32'(en), 32'h4);
    ack = 4'b0100;
    tick;
    ack = 4'b0000;
    sw = 32'h0E00_0000;
    tick;
    sw = 32'h1900_0003;
    tick;
    tick;
    chk("stb_op9", 32'(stb), 32'h0200);
    repeat (15) tick;
    ack = 4'b0001;
    tick;
    ack = 4'b0000;
    tick;
    chk("ack_wins_tie", r2, 32'h0000_0001);
    sw = 32'h1A00_0004;
    tick;
    tick;
    chk("stb_opa", 32'(stb), 32'h0400);
    sw = 32'h2B00_0005;
    tick;
    rst = 1'b1;
    sw = 32'h0;
    tick;
    chk("midrst_stb", 32'(stb), 32'h0);
    chk("midrst_en", 32'(en), 32'h0);
    chk("midrst_op", 32'(op), 32'h0);
    chk("midrst_body", 32'(body), 32'h0);
    chk("midrst_rd", r0, 32'h0);
    chk("midrst_status", r2, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("no_dropped_pend_stb", 32'(stb), 32'h0);
    end
    chk("post_rst_status", r2, 32'h0);
    sw2 = 32'h4600_0000;
    tick;
    tick;
    chk("n2_invalid_dev2", q2, 32'h2000_0000);
    chk("n2_no_stb", 32'(stb2), 32'h0);
    sw2 = 32'h2000_0000;
    tick;
    chk("n2_noop_en", 32'(en2), 32'h2);
    tick;
    chk("n2_rd_data1", q0, 32'hDEAD_BEEF);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
